crc16_frame_arbiter: RTL and testbench

- Round-robin scheduler that shares one CRC16Par32Poly0x1021KeepN transmit engine among N_REQ framed 32-bit stream sources.
- Grants one whole frame at a time and generates the engine's SyncIn, DinNd, Din, DinKeep and DinLast.
- Zero-masks the invalid bytes of the last word, enforces a minimum inter-frame gap, and latches per-frame configuration.
- Sits between the packet sources and the CRC engine's Din side.

---
 rtl/crc16_arb_pkg.sv | 31 +++
 rtl/crc16_frame_arbiter_rr.sv | 28 ++
 rtl/crc16_frame_arbiter.sv | 172 +++++++++++++++++
 tb/tb_crc16_frame_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc16_arb_pkg.sv
// Shared FSM encoding, legal last-word keep codes and keep/mask helpers for the CRC16 frame arbiter.
// Byte 3 (bits 31:24) travels first, so keep bit k guards bits 8k+7:8k.
`timescale 1ns/1ps
package crc16_arb_pkg;

  typedef enum logic [1:0] {IDLE, DATA, DRAIN, GAP} arbState_t;

  localparam logic [3:0] KEEP_1B = 4'h8;
  localparam logic [3:0] KEEP_2B = 4'hC;
  localparam logic [3:0] KEEP_3B = 4'hE;
  localparam logic [3:0] KEEP_4B = 4'hF;

  typedef struct packed {
    logic        nd;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } engBeat_t;

  function automatic logic keepIsLegal(input logic [3:0] keep);
    return (keep == KEEP_1B) || (keep == KEEP_2B) || (keep == KEEP_3B) || (keep == KEEP_4B);
  endfunction

  function automatic logic [31:0] keepToMask(input logic [3:0] keep);
    logic [31:0] mask;
    mask = '0;
    for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{keep[k]}};
    return mask;
  endfunction

endpackage

// File: rtl/crc16_frame_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at N_REQ.
// Zero latency; no flow control of its own.
`timescale 1ns/1ps
module rr_arbiter_n #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grantIdx,
  output logic             anyReq
);

  // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    grantIdx = '0;
    anyReq   = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req[j] && (j == (int'(ptr) + i) % N_REQ)) begin
          grantIdx = IDX_W'(j);
          anyReq   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/crc16_frame_arbiter.sv
// Whole-frame round-robin feed for one CRC16 engine; an accepted beat appears on Din one cycle later.
// ReqReady is decoded from state only: granted source only, high in DATA/DRAIN, low in IDLE/GAP.
`timescale 1ns/1ps
module crc16_frame_arbiter
  import crc16_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IDX_W      = 2,
  parameter int GAP_CYCLES = 5,
  parameter int MAX_WORDS  = 256
) (
  input  logic                clk,
  input  logic                Rst,
  input  logic [N_REQ-1:0]    ReqValid,
  output logic [N_REQ-1:0]    ReqReady,
  input  logic [32*N_REQ-1:0] ReqData,
  input  logic [4*N_REQ-1:0]  ReqKeep,
  input  logic [N_REQ-1:0]    ReqLast,
  input  logic                CfgFlagTR,
  input  logic [15:0]         CfgRegIni,
  output logic                SyncIn,
  output logic                DinNd,
  output logic [31:0]         Din,
  output logic [3:0]          DinKeep,
  output logic                DinLast,
  output logic                FlagTR,
  output logic [15:0]         RegIni,
  output logic [IDX_W-1:0]    GrantIdx,
  output logic                Busy,
  output logic                ErrKeep,
  output logic                ErrOverlen
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  arbState_t        state, stateNext;
  logic [IDX_W-1:0] ptr, ptrNext, grantNext, rrGrant;
  logic             rrAny;
  logic [CNT_W-1:0] wordCnt, wordCntNext;
  logic [GAP_W-1:0] gapCnt, gapCntNext;
  logic             flagNext;
  logic [15:0]      regIniNext;
  engBeat_t         beat, beatNext;
  logic             syncNext, errKeepNext, errOverNext;
  logic [31:0]      selData;
  logic [3:0]       selKeep, effKeep;
  logic             selValid, selLast, accept, portOpen;

  rr_arbiter_n #(.N_REQ(N_REQ), .IDX_W(IDX_W)) uRr (
    .req      (ReqValid),
    .ptr      (ptr),
    .grantIdx (rrGrant),
    .anyReq   (rrAny)
  );

  assign portOpen = (state == DATA) || (state == DRAIN);
  assign Busy     = (state != IDLE);

  always_comb begin
    selData  = '0;
    selKeep  = '0;
    selValid = 1'b0;
    selLast  = 1'b0;
    ReqReady = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GrantIdx == IDX_W'(i)) begin
        selData     = ReqData[32*i +: 32];
        selKeep     = ReqKeep[4*i +: 4];
        selValid    = ReqValid[i];
        selLast     = ReqLast[i];
        ReqReady[i] = portOpen;
      end
    end
  end

  assign accept = selValid && portOpen;

  always_comb begin
    stateNext   = state;
    ptrNext     = ptr;
    grantNext   = GrantIdx;
    wordCntNext = wordCnt;
    gapCntNext  = gapCnt;
    flagNext    = FlagTR;
    regIniNext  = RegIni;
    beatNext    = '0;
    syncNext    = 1'b0;
    errKeepNext = 1'b0;
    errOverNext = 1'b0;
    effKeep     = KEEP_4B;
    case (state)
      IDLE: begin
        wordCntNext = '0;
        if (rrAny) begin
          grantNext  = rrGrant;
          flagNext   = CfgFlagTR;
          regIniNext = CfgRegIni;
          ptrNext    = (rrGrant == IDX_W'(N_REQ - 1)) ? '0 : rrGrant + 1'b1;
          syncNext   = 1'b1;
          stateNext  = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          wordCntNext = wordCnt + 1'b1;
          beatNext.nd = 1'b1;
          if (selLast) begin
            if (keepIsLegal(selKeep)) effKeep = selKeep;
            else                      errKeepNext = 1'b1;
            beatNext.last = 1'b1;
            stateNext     = GAP;
            gapCntNext    = GAP_W'(GAP_CYCLES);
          end else if (wordCnt == CNT_W'(MAX_WORDS - 1)) begin
            // Truncate: close the frame towards the engine, swallow the rest of the source frame.
            beatNext.last = 1'b1;
            errOverNext   = 1'b1;
            stateNext     = DRAIN;
          end
          beatNext.data = selData & keepToMask(effKeep);
          beatNext.keep = effKeep;
        end
      end
      DRAIN: begin
        if (accept && selLast) begin
          stateNext  = GAP;
          gapCntNext = GAP_W'(GAP_CYCLES);
        end
      end
      GAP: begin
        wordCntNext = '0;
        if (gapCnt == '0) stateNext  = IDLE;
        else              gapCntNext = gapCnt - 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      ptr        <= '0;
      GrantIdx   <= '0;
      wordCnt    <= '0;
      gapCnt     <= '0;
      FlagTR     <= 1'b1;
      RegIni     <= 16'hFFFF;
      beat       <= '0;
      SyncIn     <= 1'b0;
      ErrKeep    <= 1'b0;
      ErrOverlen <= 1'b0;
    end else begin
      state      <= stateNext;
      ptr        <= ptrNext;
      GrantIdx   <= grantNext;
      wordCnt    <= wordCntNext;
      gapCnt     <= gapCntNext;
      FlagTR     <= flagNext;
      RegIni     <= regIniNext;
      beat       <= beatNext;
      SyncIn     <= syncNext;
      ErrKeep    <= errKeepNext;
      ErrOverlen <= errOverNext;
    end
  end

  assign DinNd   = beat.nd;
  assign Din     = beat.data;
  assign DinKeep = beat.keep;
  assign DinLast = beat.last;

endmodule

// File: tb/tb_crc16_frame_arbiter.sv
// Bench for crc16_frame_arbiter: scoreboarded engine beats, keep-vector table and multi-cycle sequences.
`timescale 1ns/1ps
module tb_crc16_frame_arbiter;

  localparam int N_REQ = 4, IDX_W = 2, GAP_CYCLES = 5, MAX_WORDS = 8;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  logic [N_REQ-1:0] ReqValid = '0, ReqReady, ReqLast = '0;
  logic [32*N_REQ-1:0] ReqData = '0;
  logic [4*N_REQ-1:0] ReqKeep = '0;
  logic CfgFlagTR = 1'b1;
  logic [15:0] CfgRegIni = 16'hFFFF;
  logic SyncIn, DinNd, DinLast, FlagTR, Busy, ErrKeep, ErrOverlen;
  logic [31:0] Din;
  logic [3:0] DinKeep;
  logic [15:0] RegIni;
  logic [IDX_W-1:0] GrantIdx;

  typedef struct packed {
    logic [31:0] din; logic [3:0] keep; logic last; logic errKeep; logic errOv;
  } beat_t;

  typedef struct packed {
    logic [31:0] data; logic [3:0] keep; logic tr; logic [15:0] ini; beat_t exp;
  } vec_t;

  crc16_frame_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W), .GAP_CYCLES(GAP_CYCLES), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqData(ReqData),
    .ReqKeep(ReqKeep), .ReqLast(ReqLast), .CfgFlagTR(CfgFlagTR), .CfgRegIni(CfgRegIni),
    .SyncIn(SyncIn), .DinNd(DinNd), .Din(Din), .DinKeep(DinKeep), .DinLast(DinLast),
    .FlagTR(FlagTR), .RegIni(RegIni), .GrantIdx(GrantIdx), .Busy(Busy),
    .ErrKeep(ErrKeep), .ErrOverlen(ErrOverlen)
  );

  always #5 clk = ~clk;

  int nVec = 0, nMis = 0, cyc = 0;
  beat_t sbQ[$];
  logic sbEn = 1'b1;
  int syncCnt = 0, lastCnt = 0, frameBeats = 0, lastFrameBeats = -1;
  int firstNd = -1, lastNd = -1, syncCyc = 0, lastCyc = 0;
  int grantLog[$];
  logic multiReady = 1'b0, strayErr = 1'b0;
  beat_t actB, expB;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic beat_t modelBeat(input logic [31:0] d, input logic [3:0] k, input logic isLast, input int w);
    beat_t b;
    logic legal;
    logic [3:0] ek;
    legal = (k == 4'h8) || (k == 4'hC) || (k == 4'hE) || (k == 4'hF);
    ek = (isLast && legal) ? k : 4'hF;
    b.keep = ek;
    for (int i = 0; i < 4; i++) b.din[8*i +: 8] = ek[i] ? d[8*i +: 8] : 8'h00;
    b.last    = isLast || (w == MAX_WORDS - 1);
    b.errKeep = isLast && !legal;
    b.errOv   = !isLast && (w == MAX_WORDS - 1);
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ($countones(ReqReady) > 1) multiReady = 1'b1;
    if ((ErrKeep || ErrOverlen) && !DinNd) strayErr = 1'b1;
    if (SyncIn) begin
      syncCnt++; syncCyc = cyc; frameBeats = 0; firstNd = -1;
      grantLog.push_back(int'(GrantIdx));
    end
    if (DinNd) begin
      frameBeats++;
      if (firstNd < 0) firstNd = cyc;
      lastNd = cyc;
      if (sbEn) begin
        actB = {Din, DinKeep, DinLast, ErrKeep, ErrOverlen};
        if (sbQ.size() == 0) begin
          nVec++; nMis++;
          $display("FAIL unexpected_beat: got %0h with no expected beat queued", actB);
        end else begin
          expB = sbQ.pop_front();
          chk("beat", 64'(actB), 64'(expB));
        end
      end
      if (DinLast) begin lastCnt++; lastCyc = cyc; lastFrameBeats = frameBeats; end
    end
  end

  task automatic sendFrame(input int src, input int nWords, input logic [31:0] base, input logic [3:0] lastKeep,
                           input int dropAfter, input int dropCycles, input logic useTbl, input beat_t tblExp,
                           output int accepted);
    int w, budget;
    logic [31:0] d;
    w = 0; accepted = 0;
    while (w < nWords) begin
      d = base + 32'(w);
      ReqValid[src] = 1'b1;
      ReqData[32*src +: 32] = d;
      ReqKeep[4*src +: 4] = (w == nWords - 1) ? lastKeep : 4'hF;
      ReqLast[src] = (w == nWords - 1);
      budget = 0;
      @(negedge clk);
      while (!ReqReady[src] && budget < 200) begin budget++; @(negedge clk); end
      if (!ReqReady[src]) begin
        nVec++; nMis++;
        $display("FAIL src%0d_ready_timeout: ReqReady 0 expected 1 within 200 cycles", src);
        ReqValid[src] = 1'b0; ReqLast[src] = 1'b0;
        return;
      end
      @(posedge clk);
      if (w < MAX_WORDS)
        sbQ.push_back((useTbl && w == nWords - 1) ? tblExp : modelBeat(d, ReqKeep[4*src +: 4], ReqLast[src], w));
      accepted++; w++;
      #1;
      if (dropAfter == w && dropCycles > 0 && w < nWords) begin
        ReqValid[src] = 1'b0;
        repeat (dropCycles) @(posedge clk);
        #1;
      end
    end
    ReqValid[src] = 1'b0;
    ReqLast[src]  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[6];
  int expG[6];
  int acc, acc0, acc1, acc3, s0, b;

  initial begin
    tbl[0] = '{32'hAABBCCDD, 4'hC, 1'b0, 16'h1234, '{32'hAABB0000, 4'hC, 1'b1, 1'b0, 1'b0}};
    tbl[1] = '{32'hAABBCCDD, 4'h3, 1'b1, 16'hBEEF, '{32'hAABBCCDD, 4'hF, 1'b1, 1'b1, 1'b0}};
    tbl[2] = '{32'h11223344, 4'h8, 1'b0, 16'h0000, '{32'h11000000, 4'h8, 1'b1, 1'b0, 1'b0}};
    tbl[3] = '{32'h11223344, 4'hE, 1'b1, 16'h1D0F, '{32'h11223300, 4'hE, 1'b1, 1'b0, 1'b0}};
    tbl[4] = '{32'hDEADBEEF, 4'hF, 1'b0, 16'hA5A5, '{32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0}};
    tbl[5] = '{32'hDEADBEEF, 4'h0, 1'b1, 16'h5A5A, '{32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0}};
    expG = '{0, 1, 3, 0, 1, 3};

    // Reset values, observed before any clock edge.
    #2 Rst = 1'b0;
    #2;
    chk("rst_DinNd", 64'(DinNd), 64'd0);
    chk("rst_SyncIn", 64'(SyncIn), 64'd0);
    chk("rst_DinLast", 64'(DinLast), 64'd0);
    chk("rst_Busy", 64'(Busy), 64'd0);
    chk("rst_FlagTR", 64'(FlagTR), 64'd1);
    chk("rst_RegIni", 64'(RegIni), 64'hFFFF);
    chk("rst_GrantIdx", 64'(GrantIdx), 64'd0);
    chk("rst_ReqReady", 64'(ReqReady), 64'd0);
    repeat (3) @(negedge clk);
    Rst = 1'b1;
    repeat (2) @(negedge clk);

    // Sources 0, 1, 3 continuously valid from a fresh pointer.
    grantLog.delete();
    fork
      begin sendFrame(0, 2, 32'hA0000000, 4'hF, 0, 0, 1'b0, '0, acc0); sendFrame(0, 2, 32'hA0000010, 4'hC, 0, 0, 1'b0, '0, acc0); end
      begin sendFrame(1, 2, 32'hB0000000, 4'hE, 0, 0, 1'b0, '0, acc1); sendFrame(1, 2, 32'hB0000010, 4'hF, 0, 0, 1'b0, '0, acc1); end
      begin sendFrame(3, 2, 32'hD0000000, 4'h8, 0, 0, 1'b0, '0, acc3); sendFrame(3, 2, 32'hD0000010, 4'hF, 0, 0, 1'b0, '0, acc3); end
    join
    repeat (GAP_CYCLES + 5) @(negedge clk);
    chk("rr_grant_count", 64'(grantLog.size()), 64'd6);
    for (int i = 0; i < 6 && i < grantLog.size(); i++) chk("rr_grant", 64'(grantLog[i]), 64'(expG[i]));
    chk("rr_ready_onehot", 64'(multiReady), 64'd0);

    // Five-word frame, then a follow-up to measure the enforced gap.
    sendFrame(0, 5, 32'h12345678, 4'hF, 0, 0, 1'b0, '0, acc);
    repeat (2) @(negedge clk);
    chk("five_beats", 64'(lastFrameBeats), 64'd5);
    chk("five_sync_to_nd", 64'(firstNd - syncCyc), 64'd1);
    sendFrame(0, 1, 32'h0BADF00D, 4'hF, 0, 0, 1'b0, '0, acc);
    chk("gap_last_to_sync", 64'(syncCyc - lastCyc), 64'(GAP_CYCLES + 2));
    repeat (GAP_CYCLES + 4) @(negedge clk);

    // Keep/masking table on single-word frames; config flipped mid-frame must not take.
    for (int i = 0; i < 6; i++) begin
      CfgFlagTR = tbl[i].tr;
      CfgRegIni = tbl[i].ini;
      lastFrameBeats = -1;
      s0 = syncCnt;
      fork
        sendFrame(2, 1, tbl[i].data, tbl[i].keep, 0, 0, 1'b1, tbl[i].exp, acc);
        begin
          b = 0;
          while (syncCnt == s0 && b < 100) begin @(negedge clk); b++; end
          #1;
          CfgFlagTR = ~tbl[i].tr;
          CfgRegIni = ~tbl[i].ini;
        end
      join
      repeat (3) @(negedge clk);
      chk("single_beats", 64'(lastFrameBeats), 64'd1);
      chk("single_sync_to_nd", 64'(firstNd - syncCyc), 64'd1);
      chk("latched_RegIni", 64'(RegIni), 64'(tbl[i].ini));
      chk("latched_FlagTR", 64'(FlagTR), 64'(tbl[i].tr));
      repeat (GAP_CYCLES + 2) @(negedge clk);
    end

    // Over-length frame: truncated at MAX_WORDS, remainder drained.
    lastFrameBeats = -1;
    sendFrame(1, MAX_WORDS + 2, 32'hC0DE0000, 4'hF, 0, 0, 1'b0, '0, acc);
    chk("drain_ready_in_gap", 64'(ReqReady), 64'd0);
    chk("drain_busy_in_gap", 64'(Busy), 64'd1);
    chk("drain_accepted", 64'(acc), 64'(MAX_WORDS + 2));
    repeat (3) @(negedge clk);
    chk("overlen_beats", 64'(lastFrameBeats), 64'(MAX_WORDS));
    repeat (GAP_CYCLES + 2) @(negedge clk);

    // Three-cycle source bubble mid-frame.
    s0 = syncCnt;
    lastFrameBeats = -1;
    sendFrame(3, 6, 32'h5A5A0000, 4'hE, 2, 3, 1'b0, '0, acc);
    repeat (3) @(negedge clk);
    chk("bubble_sync_count", 64'(syncCnt - s0), 64'd1);
    chk("bubble_beats", 64'(lastFrameBeats), 64'd6);
    chk("bubble_span", 64'(lastNd - firstNd), 64'd8);
    repeat (GAP_CYCLES + 3) @(negedge clk);
    chk("sb_drained", 64'(sbQ.size()), 64'd0);
    chk("no_stray_err", 64'(strayErr), 64'd0);

    // Reset while a beat is on DinNd.
    sbEn = 1'b0;
    ReqData[64 +: 32] = 32'h77777777;
    ReqKeep[8 +: 4] = 4'hF;
    ReqLast[2] = 1'b0;
    ReqValid[2] = 1'b1;
    b = 0;
    @(negedge clk);
    while (!DinNd && b < 50) begin @(negedge clk); b++; end
    chk("rst_mid_saw_beat", 64'(DinNd), 64'd1);
    Rst = 1'b0;
    #1;
    chk("rst_mid_DinNd", 64'(DinNd), 64'd0);
    chk("rst_mid_SyncIn", 64'(SyncIn), 64'd0);
    chk("rst_mid_DinLast", 64'(DinLast), 64'd0);
    chk("rst_mid_Busy", 64'(Busy), 64'd0);
    ReqValid = '0;
    CfgRegIni = 16'h1D0F;
    repeat (2) @(negedge clk);
    Rst = 1'b1;
    #1;
    chk("rst_rel_RegIni", 64'(RegIni), 64'hFFFF);
    ReqLast  = 4'b1001;
    ReqKeep  = 16'hF00F;
    ReqValid = 4'b1001;
    b = 0;
    @(negedge clk);
    while (!SyncIn && b < 20) begin @(negedge clk); b++; end
    chk("rst_rel_sync", 64'(SyncIn), 64'd1);
    chk("rst_rel_grant", 64'(GrantIdx), 64'd0);
    chk("rst_rel_RegIni_latched", 64'(RegIni), 64'h1D0F);
    ReqValid = '0;
    ReqLast  = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
